jb_iq_slew_protect: RTL and testbench

- Companion block to the IQ slew error detector in the PA protection path. Two roles:
  - Produces the detector's {q,i} current/previous sample pair from the incoming IQ stream.
  - Consumes the detector's slew error flag, counts errors per window, and trips PA protection when the limit is reached.
- On trip: ramps IQ gain down to mute, holds off, then ramps back to full scale.
- Sits between the DAC-bound IQ stream and the DAC interface.

---
 rtl/jb_iq_slew_protect.sv | 279 +++++++++++++++++++++++++++
 tb/tb_jb_iq_slew_protect.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_iq_slew_protect.sv
`default_nettype none
// ============================================================================
// Module   : jb_iq_slew_protect
// Purpose  : PA protection companion to the IQ slew error detector.
//            - Feeds the detector with the current/previous valid {q,i} pair.
//            - Counts detector errors per window and trips when the limit is
//              reached; on a trip the IQ gain ramps to mute, holds off, then
//              ramps back to full scale.
//            - Applies the gain to the DAC-bound IQ stream (2-cycle latency).
// Ports    : clk, reset (sync, active-high)
//            iq_in/iq_in_valid        : DAC-bound input stream {q,i}
//            iq_slew_error, enable    : detector flag and monitoring enable
//            clear_trip               : early release from MUTED
//            win_len, err_limit, holdoff_len, ramp_step_len : live config
//            iq_current/iq_previous   : sample pair to the detector
//            iq_out/iq_out_valid      : gain-scaled stream to the DAC
//            pa_trip, trip_count, state : protection status
// Revision : 1.0 - initial release
// ============================================================================
module jb_iq_slew_protect #(
    parameter int IQ_PRECISION = 16,
    parameter int GAIN_FRAC    = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*IQ_PRECISION-1:0] iq_in,
    input  logic                      iq_in_valid,
    input  logic                      iq_slew_error,
    input  logic                      enable,
    input  logic                      clear_trip,
    input  logic [15:0]               win_len,
    input  logic [7:0]                err_limit,
    input  logic [15:0]               holdoff_len,
    input  logic [15:0]               ramp_step_len,
    output logic [2*IQ_PRECISION-1:0] iq_current,
    output logic [2*IQ_PRECISION-1:0] iq_previous,
    output logic [2*IQ_PRECISION-1:0] iq_out,
    output logic                      iq_out_valid,
    output logic                      pa_trip,
    output logic [15:0]               trip_count,
    output logic [2:0]                state
);

    localparam int c_GAIN_W = GAIN_FRAC + 1;
    localparam int c_PROD_W = IQ_PRECISION + GAIN_FRAC + 2;

    localparam logic [c_GAIN_W-1:0] c_GAIN_UNITY    = {1'b1, {GAIN_FRAC{1'b0}}};
    localparam logic [c_GAIN_W-1:0] c_GAIN_UNITY_M1 = {1'b0, {GAIN_FRAC{1'b1}}};
    localparam logic [c_GAIN_W-1:0] c_GAIN_ZERO     = '0;
    localparam logic [c_GAIN_W-1:0] c_GAIN_ONE      = {{GAIN_FRAC{1'b0}}, 1'b1};

    localparam logic signed [c_PROD_W-1:0] c_SAT_MAX =
        {{(c_PROD_W-IQ_PRECISION+1){1'b0}}, {(IQ_PRECISION-1){1'b1}}};
    localparam logic signed [c_PROD_W-1:0] c_SAT_MIN =
        {{(c_PROD_W-IQ_PRECISION+1){1'b1}}, {(IQ_PRECISION-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_ARMED     = 3'd0,
        ST_RAMP_DOWN = 3'd1,
        ST_MUTED     = 3'd2,
        ST_RAMP_UP   = 3'd3
    } state_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t              r_state,      w_state_nxt;
    logic [c_GAIN_W-1:0] r_gain,       w_gain_nxt;
    logic [15:0]         r_win_cnt,    w_win_cnt_nxt;
    logic [7:0]          r_err_cnt,    w_err_cnt_nxt;
    logic [15:0]         r_step_cnt,   w_step_cnt_nxt;
    logic [15:0]         r_hold_cnt,   w_hold_cnt_nxt;
    logic [15:0]         r_trip_count, w_trip_count_nxt;

    logic        w_err;
    logic [15:0] w_win_last;
    logic        w_win_wrap;
    logic [7:0]  w_err_limit;
    logic [7:0]  w_err_base;
    logic [8:0]  w_err_sum;
    logic        w_trip_now;
    logic        w_step_tc;
    logic        w_hold_done;
    logic [15:0] w_trip_count_inc;

    always_comb begin
        w_err      = enable & iq_slew_error;
        // Zero window / zero limit behave as one.
        w_win_last  = (win_len == 16'd0) ? 16'd0 : (win_len - 16'd1);
        w_err_limit = (err_limit == 8'd0) ? 8'd1 : err_limit;
        // >= rather than == so a live shrink of win_len wraps immediately.
        w_win_wrap  = (r_win_cnt >= w_win_last);
        // An error in the wrap cycle belongs to the fresh window.
        w_err_base  = w_win_wrap ? 8'd0 : r_err_cnt;
        w_err_sum   = {1'b0, w_err_base} + 9'd1;
        w_trip_now  = w_err && (w_err_sum >= {1'b0, w_err_limit});
        w_step_tc   = (r_step_cnt >= ramp_step_len);
        w_hold_done = (holdoff_len != 16'd0) && (r_hold_cnt >= (holdoff_len - 16'd1));
        w_trip_count_inc = (r_trip_count == 16'hFFFF) ? r_trip_count
                                                      : (r_trip_count + 16'd1);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gain_nxt       = r_gain;
        w_win_cnt_nxt    = r_win_cnt;
        w_err_cnt_nxt    = r_err_cnt;
        w_step_cnt_nxt   = r_step_cnt;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_trip_count_nxt = r_trip_count;

        case (r_state)
            ST_ARMED: begin
                if (w_win_wrap) begin
                    w_win_cnt_nxt = 16'd0;
                    w_err_cnt_nxt = w_err ? 8'd1 : 8'd0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + 16'd1;
                    if (w_err && (r_err_cnt != 8'hFF)) begin
                        w_err_cnt_nxt = r_err_cnt + 8'd1;
                    end
                end
                if (w_trip_now) begin
                    w_state_nxt      = ST_RAMP_DOWN;
                    w_trip_count_nxt = w_trip_count_inc;
                    w_step_cnt_nxt   = 16'd0;
                end
            end

            ST_RAMP_DOWN: begin
                if (r_gain == c_GAIN_ZERO) begin
                    // Re-trip from the very bottom of a ramp-up.
                    w_state_nxt    = ST_MUTED;
                    w_hold_cnt_nxt = 16'd0;
                end else if (w_step_tc) begin
                    w_step_cnt_nxt = 16'd0;
                    w_gain_nxt     = r_gain - c_GAIN_ONE;
                    if (r_gain == c_GAIN_ONE) begin
                        w_state_nxt    = ST_MUTED;
                        w_hold_cnt_nxt = 16'd0;
                    end
                end else begin
                    w_step_cnt_nxt = r_step_cnt + 16'd1;
                end
            end

            ST_MUTED: begin
                w_gain_nxt     = c_GAIN_ZERO;
                w_hold_cnt_nxt = r_hold_cnt + 16'd1;
                if (clear_trip || w_hold_done) begin
                    w_state_nxt    = ST_RAMP_UP;
                    w_step_cnt_nxt = 16'd0;
                end
            end

            ST_RAMP_UP: begin
                // The error takes priority over the final unity step.
                if (w_err) begin
                    w_state_nxt      = ST_RAMP_DOWN;
                    w_trip_count_nxt = w_trip_count_inc;
                    w_step_cnt_nxt   = 16'd0;
                end else if (r_gain >= c_GAIN_UNITY) begin
                    w_gain_nxt    = c_GAIN_UNITY;
                    w_state_nxt   = ST_ARMED;
                    w_win_cnt_nxt = 16'd0;
                    w_err_cnt_nxt = 8'd0;
                end else if (w_step_tc) begin
                    w_step_cnt_nxt = 16'd0;
                    w_gain_nxt     = r_gain + c_GAIN_ONE;
                    if (r_gain == c_GAIN_UNITY_M1) begin
                        w_state_nxt   = ST_ARMED;
                        w_win_cnt_nxt = 16'd0;
                        w_err_cnt_nxt = 8'd0;
                    end
                end else begin
                    w_step_cnt_nxt = r_step_cnt + 16'd1;
                end
            end

            default: begin
                w_state_nxt = ST_ARMED;
                w_gain_nxt  = c_GAIN_UNITY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ARMED;
            r_gain       <= c_GAIN_UNITY;
            r_win_cnt    <= 16'd0;
            r_err_cnt    <= 8'd0;
            r_step_cnt   <= 16'd0;
            r_hold_cnt   <= 16'd0;
            r_trip_count <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_gain       <= w_gain_nxt;
            r_win_cnt    <= w_win_cnt_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_step_cnt   <= w_step_cnt_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_trip_count <= w_trip_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: detector feed and 2-stage gain scaling
    // ------------------------------------------------------------------
    function automatic logic [IQ_PRECISION-1:0] f_sat(input logic signed [c_PROD_W-1:0] v);
        if (v > c_SAT_MAX) begin
            return {1'b0, {(IQ_PRECISION-1){1'b1}}};
        end else if (v < c_SAT_MIN) begin
            return {1'b1, {(IQ_PRECISION-1){1'b0}}};
        end else begin
            return v[IQ_PRECISION-1:0];
        end
    endfunction

    logic signed [IQ_PRECISION-1:0] w_in_i;
    logic signed [IQ_PRECISION-1:0] w_in_q;
    logic signed [c_GAIN_W:0]       w_gain_s;
    logic signed [c_PROD_W-1:0]     w_prod_i;
    logic signed [c_PROD_W-1:0]     w_prod_q;
    logic signed [c_PROD_W-1:0]     w_shift_i;
    logic signed [c_PROD_W-1:0]     w_shift_q;

    logic signed [c_PROD_W-1:0]     r_prod_i;
    logic signed [c_PROD_W-1:0]     r_prod_q;
    logic                           r_valid_d1;
    logic [2*IQ_PRECISION-1:0]      r_iq_current;
    logic [2*IQ_PRECISION-1:0]      r_iq_previous;
    logic [2*IQ_PRECISION-1:0]      r_iq_out;
    logic                           r_iq_out_valid;

    always_comb begin
        w_in_i   = iq_in[IQ_PRECISION-1:0];
        w_in_q   = iq_in[2*IQ_PRECISION-1:IQ_PRECISION];
        // Gain is unsigned; the extra zero MSB keeps it positive in signed math.
        w_gain_s = {1'b0, r_gain};
        w_prod_i = c_PROD_W'(w_in_i) * c_PROD_W'(w_gain_s);
        w_prod_q = c_PROD_W'(w_in_q) * c_PROD_W'(w_gain_s);
        // Arithmetic shift gives floor rounding for negative samples.
        w_shift_i = r_prod_i >>> GAIN_FRAC;
        w_shift_q = r_prod_q >>> GAIN_FRAC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod_i       <= '0;
            r_prod_q       <= '0;
            r_valid_d1     <= 1'b0;
            r_iq_current   <= '0;
            r_iq_previous  <= '0;
            r_iq_out       <= '0;
            r_iq_out_valid <= 1'b0;
        end else begin
            r_prod_i       <= w_prod_i;
            r_prod_q       <= w_prod_q;
            r_valid_d1     <= iq_in_valid;
            r_iq_out       <= {f_sat(w_shift_q), f_sat(w_shift_i)};
            r_iq_out_valid <= r_valid_d1;
            if (iq_in_valid) begin
                r_iq_previous <= r_iq_current;
                r_iq_current  <= iq_in;
            end
        end
    end

    assign iq_current   = r_iq_current;
    assign iq_previous  = r_iq_previous;
    assign iq_out       = r_iq_out;
    assign iq_out_valid = r_iq_out_valid;
    assign pa_trip      = (r_state != ST_ARMED);
    assign trip_count   = r_trip_count;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jb_iq_slew_protect.sv
`default_nettype none
// ============================================================================
// Module   : tb_jb_iq_slew_protect
// Purpose  : Directed self-checking bench for jb_iq_slew_protect.
//            Inputs change 1ns after the rising edge; outputs are checked at
//            the same point, i.e. they reflect the edge just taken.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jb_iq_slew_protect;

    logic        clk;
    logic        reset;
    logic [31:0] iq_in;
    logic        iq_in_valid;
    logic        iq_slew_error;
    logic        enable;
    logic        clear_trip;
    logic [15:0] win_len;
    logic [7:0]  err_limit;
    logic [15:0] holdoff_len;
    logic [15:0] ramp_step_len;
    logic [31:0] iq_current;
    logic [31:0] iq_previous;
    logic [31:0] iq_out;
    logic        iq_out_valid;
    logic        pa_trip;
    logic [15:0] trip_count;
    logic [2:0]  state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    jb_iq_slew_protect #(
        .IQ_PRECISION (16),
        .GAIN_FRAC    (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .iq_in         (iq_in),
        .iq_in_valid   (iq_in_valid),
        .iq_slew_error (iq_slew_error),
        .enable        (enable),
        .clear_trip    (clear_trip),
        .win_len       (win_len),
        .err_limit     (err_limit),
        .holdoff_len   (holdoff_len),
        .ramp_step_len (ramp_step_len),
        .iq_current    (iq_current),
        .iq_previous   (iq_previous),
        .iq_out        (iq_out),
        .iq_out_valid  (iq_out_valid),
        .pa_trip       (pa_trip),
        .trip_count    (trip_count),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        iq_in         = 32'h0;
        iq_in_valid   = 1'b0;
        iq_slew_error = 1'b0;
        enable        = 1'b1;
        clear_trip    = 1'b0;
        win_len       = 16'd100;
        err_limit     = 8'd3;
        holdoff_len   = 16'd10;
        ramp_step_len = 16'd0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_state",     32'(state), 32'd0);
        chk("rst_pa_trip",   32'(pa_trip), 32'd0);
        chk("rst_trip_cnt",  32'(trip_count), 32'd0);
        chk("rst_iq_out",    iq_out, 32'h0);
        chk("rst_out_valid", 32'(iq_out_valid), 32'd0);
        chk("rst_current",   iq_current, 32'h0);
        chk("rst_previous",  iq_previous, 32'h0);

        // ---------------- pass-through ----------------
        reset       = 1'b0;
        iq_in       = 32'h8000_7FFF;
        iq_in_valid = 1'b1;
        tick();
        chk("pt_cur_a",   iq_current, 32'h8000_7FFF);
        chk("pt_prev_a",  iq_previous, 32'h0);
        chk("pt_valid_0", 32'(iq_out_valid), 32'd0);
        iq_in = 32'h0001_FFFF;
        tick();
        chk("pt_out_a",   iq_out, 32'h8000_7FFF);
        chk("pt_valid_a", 32'(iq_out_valid), 32'd1);
        chk("pt_prev_b",  iq_previous, 32'h8000_7FFF);
        iq_in = 32'h7FFF_8000;
        tick();
        chk("pt_out_b",   iq_out, 32'h0001_FFFF);
        chk("pt_cur_c",   iq_current, 32'h7FFF_8000);
        iq_in_valid = 1'b0;
        iq_in       = 32'h5555_5555;
        tick();
        chk("pt_out_c",   iq_out, 32'h7FFF_8000);
        chk("pt_hold_cur",  iq_current, 32'h7FFF_8000);
        chk("pt_hold_prev", iq_previous, 32'h0001_FFFF);
        tick();
        chk("pt_valid_end", 32'(iq_out_valid), 32'd0);
        chk("pt_no_trip",   32'(pa_trip), 32'd0);

        // ---------------- trip and recover ----------------
        // i=128, q=0: iq_out low half reads back the gain two cycles earlier.
        iq_in       = 32'h0000_0080;
        iq_in_valid = 1'b1;
        win_len     = 16'd100;
        err_limit   = 8'd3;
        holdoff_len = 16'd10;
        ramp_step_len = 16'd0;
        do_reset();
        iq_slew_error = 1'b1;
        tick();
        tick();
        chk("tr_two_err_armed", 32'(state), 32'd0);
        tick();
        iq_slew_error = 1'b0;
        chk("tr_rampdown",   32'(state), 32'd1);
        chk("tr_pa_trip",    32'(pa_trip), 32'd1);
        chk("tr_trip_cnt",   32'(trip_count), 32'd1);
        repeat (127) tick();
        chk("tr_still_down", 32'(state), 32'd1);
        tick();
        chk("tr_muted",      32'(state), 32'd2);
        chk("tr_gain_tail",  iq_out, 32'h0000_0002);
        repeat (9) tick();
        chk("tr_muted_end",  32'(state), 32'd2);
        tick();
        chk("tr_rampup",     32'(state), 32'd3);
        chk("tr_muted_out",  iq_out, 32'h0000_0000);
        repeat (127) tick();
        chk("tr_still_up",   32'(state), 32'd3);
        tick();
        chk("tr_armed",      32'(state), 32'd0);
        chk("tr_armed_pa",   32'(pa_trip), 32'd0);
        chk("tr_final_cnt",  32'(trip_count), 32'd1);
        chk("tr_up_tail",    iq_out, 32'h0000_007E);
        repeat (2) tick();
        chk("tr_unity",      iq_out, 32'h0000_0080);

        // ---------------- window expiry ----------------
        win_len   = 16'd50;
        err_limit = 8'd2;
        do_reset();
        repeat (10) tick();
        iq_slew_error = 1'b1;
        tick();
        iq_slew_error = 1'b0;
        repeat (49) tick();
        iq_slew_error = 1'b1;
        tick();
        iq_slew_error = 1'b0;
        chk("win_no_trip",  32'(state), 32'd0);
        chk("win_cnt_zero", 32'(trip_count), 32'd0);
        iq_slew_error = 1'b1;
        tick();
        iq_slew_error = 1'b0;
        chk("win_trip",     32'(state), 32'd1);
        chk("win_trip_cnt", 32'(trip_count), 32'd1);

        // ---------------- latched mute (err_limit 0 acts as 1) ----------------
        win_len     = 16'd100;
        err_limit   = 8'd0;
        holdoff_len = 16'd0;
        do_reset();
        iq_slew_error = 1'b1;
        tick();
        iq_slew_error = 1'b0;
        chk("lm_trip",     32'(state), 32'd1);
        chk("lm_trip_cnt", 32'(trip_count), 32'd1);
        clear_trip = 1'b1;
        tick();
        clear_trip = 1'b0;
        chk("lm_clear_ignored", 32'(state), 32'd1);
        repeat (126) tick();
        chk("lm_still_down", 32'(state), 32'd1);
        tick();
        chk("lm_muted", 32'(state), 32'd2);
        repeat (1000) tick();
        chk("lm_latched",  32'(state), 32'd2);
        chk("lm_out_zero", iq_out, 32'h0000_0000);
        clear_trip = 1'b1;
        tick();
        clear_trip = 1'b0;
        chk("lm_released", 32'(state), 32'd3);

        // ---------------- re-trip during RAMP_UP ----------------
        repeat (64) tick();
        iq_slew_error = 1'b1;
        tick();
        iq_slew_error = 1'b0;
        ramp_step_len = 16'd3;
        chk("rt_rampdown", 32'(state), 32'd1);
        chk("rt_trip_cnt", 32'(trip_count), 32'd2);
        chk("rt_out_63",   iq_out, 32'h0000_003F);
        repeat (2) tick();
        chk("rt_hold_64",  iq_out, 32'h0000_0040);
        repeat (3) tick();
        chk("rt_still_64", iq_out, 32'h0000_0040);
        tick();
        chk("rt_step_63",  iq_out, 32'h0000_003F);
        repeat (4) tick();
        chk("rt_step_62",  iq_out, 32'h0000_003E);

        // ---------------- scaling and mid-ramp reset ----------------
        iq_in         = 32'h0003_FFFD;
        err_limit     = 8'd1;
        holdoff_len   = 16'd10;
        ramp_step_len = 16'd0;
        do_reset();
        iq_slew_error = 1'b1;
        tick();
        iq_slew_error = 1'b0;
        repeat (66) tick();
        chk("sc_state",     32'(state), 32'd1);
        chk("sc_floor_g64", iq_out, 32'h0001_FFFE);
        reset = 1'b1;
        tick();
        chk("mr_state",     32'(state), 32'd0);
        chk("mr_pa_trip",   32'(pa_trip), 32'd0);
        chk("mr_trip_cnt",  32'(trip_count), 32'd0);
        chk("mr_iq_out",    iq_out, 32'h0);
        chk("mr_valid",     32'(iq_out_valid), 32'd0);
        chk("mr_current",   iq_current, 32'h0);
        chk("mr_previous",  iq_previous, 32'h0);
        reset = 1'b0;
        tick();
        tick();
        chk("mr_unity_out", iq_out, 32'h0003_FFFD);
        chk("mr_unity_vld", 32'(iq_out_valid), 32'd1);

        // ---------------- win_len 0 acts as a 1-cycle window ----------------
        win_len   = 16'd0;
        err_limit = 8'd2;
        do_reset();
        iq_slew_error = 1'b1;
        repeat (5) tick();
        iq_slew_error = 1'b0;
        chk("w0_no_trip", 32'(state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
